rom_arbiter_n: RTL and testbench
================================

Name: rom_arbiter_n

Overview:
Parametrised N-channel SDRAM read arbiter with an integrated IOCTL download writer. It sits between the per-ROM segment caches and the single 32-bit SDRAM controller, and supersedes the fixed four-channel controller. Supported behaviour:
- selectable fixed-priority or round-robin arbitration;
- a tag FIFO so the SDRAM may hold several reads in flight (ack-to-valid pipelining);
- byte-to-word download packing, with a flush of any trailing partial word.

Parameters:
NUM_CH, 4, number of read channels (1..8)
ADDR_W, 23, SDRAM word address width
DATA_W, 32, SDRAM data width (fixed 32 in this generation; other values rejected at elaboration)
ARB_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
MAX_OUTSTANDING, 2, depth of the in-flight tag FIFO (power of two, >= 1)
DL_INDEX, 0, ioctl_index value that enables SDRAM writes

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel read request; held by the requester until its ch_ack
ch_addr  in  NUM_CH*ADDR_W  flattened word addresses; channel i occupies [i*ADDR_W +: ADDR_W]
ch_ack  out  NUM_CH  one-hot ack pulse to the granted channel
ch_valid  out  NUM_CH  one-hot data-valid pulse to the owning channel
ch_q  out  DATA_W  shared read data (= sdram_q)
ioctl_addr  in  25  byte address
ioctl_data  in  8  download byte
ioctl_index  in  16  download index
ioctl_wr  in  1  byte strobe
ioctl_download  in  1  download active
sdram_addr  out  ADDR_W  registered request address
sdram_data  out  DATA_W  registered write data
sdram_we  out  1  registered write enable
sdram_req  out  1  registered request
sdram_ack  in  1  request accepted
sdram_valid  in  1  read data valid
sdram_q  in  DATA_W  read data
err_orphan  out  1  sticky flag: sdram_valid arrived with the tag FIFO empty
err_overrun  out  1  sticky flag: a 4th byte completed while a download write was still pending

Behaviour:
- Reset values (all outputs): 0. This covers sdram_*, ch_ack, ch_valid, the err flags and the RR pointer (last granted = NUM_CH-1). Tag FIFO and packer are emptied.
- FSM states: IDLE, RD_REQ, WR_REQ.
- IDLE:
  - If ioctl_download=1 and a packed word is ready: register addr/data, we = (ioctl_index==DL_INDEX), sdram_req=1, go to WR_REQ.
  - Else if ioctl_download=0, any ch_req=1 and the tag FIFO is not full: arbitrate, register the winner's addr, we=0, sdram_req=1, go to RD_REQ.
  - Latency: req seen in cycle N gives sdram_req=1 in cycle N+1.
- RD_REQ / WR_REQ: hold sdram_req, addr, data and we stable until sdram_ack=1.
  - In the ack cycle, sdram_req drops on the next edge and the FSM returns to IDLE. At most one grant per two cycles.
  - RD_REQ only: ch_ack[grant]=sdram_ack (combinational, same cycle), and the grant ID is pushed into the tag FIFO.
- Arbitration:
  - Mode 0: lowest index wins.
  - Mode 1: search begins at last_grant+1, modulo NUM_CH. last_grant updates only on sdram_ack.
- Return path: on sdram_valid=1, ch_valid[fifo_head]=1 in the same cycle and the FIFO pops. ch_q = sdram_q always.
- Simultaneous push (ack) and pop (valid) in one cycle: occupancy unchanged.
- sdram_valid with the FIFO empty: no ch_valid; err_orphan sets.
- Channel-side requirement: a channel must not drop ch_req before ack. If it does while in RD_REQ, the request still completes and the ack/valid pulses go to that channel.
- Download packer:
  - Bytes are packed little-endian. Byte k goes to bits [8k+7:8k] with k = ioctl_addr[1:0].
  - A word is ready when byte 3 is written. Write address = ioctl_addr[24:2].
  - A new ready word while WR_REQ is still pending: the old word is kept and the new one dropped; err_overrun sets.
- Falling edge of ioctl_download with a partial word: one flush write is issued with unwritten bytes = 0. Reads stay blocked until it is acked.
- ioctl_download rising while in RD_REQ: that read completes normally. No new read is granted until download ends and the flush is done.
- In-flight reads still drain via the tag FIFO during a download.

Decomposition:
- Package rom_arbiter_pkg holds:
  - FSM state enum (IDLE/RD_REQ/WR_REQ);
  - ARB_FIXED / ARB_RR constants;
  - function clog2_safe for the tag width (max(1, clog2(NUM_CH))).
- Sub-module rom_download_packer: byte lanes, ready flag, flush on download end, overrun detect.
- The tag FIFO is inline; it is small enough to stay in the top module.

Test Plan:
- NUM_CH=4, ARB_MODE=0, ch_req=4'b1010 held, sdram_ack one cycle after each sdram_req → grant order 1,1,1… (ch3 starved); ch_ack[1] coincides with sdram_ack; sdram_addr = ch_addr[1].
- ARB_MODE=1, ch_req=4'b1111 held → grant order 0,1,2,3,0; last_grant wraps from 3 to 0.
- MAX_OUTSTANDING=2: two reads acked (ch2, then ch0) before any valid, then sdram_valid twice → ch_valid[2] then ch_valid[0]; a third request waits until the first valid. Spurious extra valid → err_orphan=1, no ch_valid.
- Download bytes 0x11,0x22,0x33,0x44 at addr 0x100..0x103, index 0 → one write: addr 0x40, data 0x44332211, we=1. With index 1 → same request with we=0.
- Download 6 bytes at 0x00..0x05, then drop ioctl_download → second write: addr 0x1, data 0x0000_BBAA (bytes 4,5 = AA,BB). A ch_req raised during the download is granted only after the flush ack.
- Assert reset_n=0 mid RD_REQ with one tag pending → all outputs 0 asynchronously and the FIFO empties. A later sdram_valid → err_orphan=1.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared types and helpers for the ROM SDRAM read arbiter.
//   arb_state_e  - request FSM state (IDLE / RD_REQ / WR_REQ)
//   ARB_FIXED    - fixed priority arbitration, channel 0 highest
//   ARB_RR       - round-robin arbitration
//   clog2_safe   - ceil(log2(n)) but never less than 1, for tag/pointer widths
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2_safe(input int n);
    int r;
    r = (n <= 1) ? 1 : $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/rom_download_packer.sv
// rom_download_packer: packs IOCTL download bytes into little-endian 32-bit
// words and presents one ready word at a time to the arbiter FSM.
//   clk, reset_n        - clock, asynchronous active-low reset
//   ioctl_*_i           - download byte stream
//   wr_done_i           - the pending write was accepted by the SDRAM
//   word_rdy_o          - a packed word waits for (or is being) written
//   word_addr_o/data_o  - word address (byte address / 4) and data
//   busy_o              - a word is pending or a trailing flush is being formed
//   overrun_o           - sticky: a word completed while one was still pending
module rom_download_packer
  import rom_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_data_i,
  input  logic        ioctl_wr_i,
  input  logic        ioctl_download_i,
  input  logic        wr_done_i,
  output logic        word_rdy_o,
  output logic [22:0] word_addr_o,
  output logic [31:0] word_data_o,
  output logic        busy_o,
  output logic        overrun_o
);

  logic [31:0] lane_q;
  logic [3:0]  lane_vld_q;
  logic [22:0] lane_addr_q;
  logic        dl_q;
  logic        rdy_q;
  logic [22:0] out_addr_q;
  logic [31:0] out_data_q;
  logic        ovr_q;

  logic        byte_wr_s;
  logic [1:0]  lane_s;
  logic        full_s;
  logic        flush_s;
  logic        complete_s;
  logic        slot_free_s;
  logic [31:0] merged_s;

  assign byte_wr_s   = ioctl_wr_i & ioctl_download_i;
  assign lane_s      = ioctl_addr_i[1:0];
  assign full_s      = byte_wr_s & (lane_s == 2'd3);
  // Download just ended with some bytes collected: emit them as a final word.
  assign flush_s     = dl_q & ~ioctl_download_i & (|lane_vld_q);
  assign complete_s  = full_s | flush_s;
  // The slot frees in the same cycle the previous write is acked.
  assign slot_free_s = ~rdy_q | wr_done_i;

  // Current lane buffer with the incoming byte merged into its lane.
  always_comb begin
    merged_s = lane_q;
    case (lane_s)
      2'd0:    merged_s[7:0]   = ioctl_data_i;
      2'd1:    merged_s[15:8]  = ioctl_data_i;
      2'd2:    merged_s[23:16] = ioctl_data_i;
      2'd3:    merged_s[31:24] = ioctl_data_i;
      default: merged_s        = lane_q;
    endcase
  end

  // Lane buffer, ready slot and overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q      <= 32'd0;
      lane_vld_q  <= 4'd0;
      lane_addr_q <= 23'd0;
      dl_q        <= 1'b0;
      rdy_q       <= 1'b0;
      out_addr_q  <= 23'd0;
      out_data_q  <= 32'd0;
      ovr_q       <= 1'b0;
    end else begin
      dl_q <= ioctl_download_i;
      // Lanes restart empty after every word so unwritten bytes read as zero.
      if (complete_s) begin
        lane_q     <= 32'd0;
        lane_vld_q <= 4'd0;
      end else if (byte_wr_s) begin
        lane_q      <= merged_s;
        lane_vld_q  <= lane_vld_q | (4'b0001 << lane_s);
        lane_addr_q <= ioctl_addr_i[24:2];
      end
      if (complete_s && slot_free_s) begin
        rdy_q      <= 1'b1;
        out_addr_q <= full_s ? ioctl_addr_i[24:2] : lane_addr_q;
        out_data_q <= full_s ? merged_s : lane_q;
      end else if (wr_done_i) begin
        rdy_q <= 1'b0;
      end
      // The pending word wins; the newly completed one is lost.
      if (complete_s && !slot_free_s) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign word_rdy_o  = rdy_q;
  assign word_addr_o = out_addr_q;
  assign word_data_o = out_data_q;
  assign busy_o      = rdy_q | flush_s;
  assign overrun_o   = ovr_q;

endmodule

// File: rtl/rom_arbiter_n.sv
// rom_arbiter_n: N-channel SDRAM read arbiter with an IOCTL download writer.
//   clk, reset_n       - clock, asynchronous active-low reset
//   ch_req/ch_addr     - per-channel read requests and flattened word addresses
//   ch_ack/ch_valid    - one-hot accept / data-valid pulses; ch_q = shared data
//   ioctl_*            - byte download stream (written when index == DL_INDEX)
//   sdram_*            - registered request side and return side of the SDRAM
//   err_orphan         - sticky: read data arrived with no read outstanding
//   err_overrun        - sticky: a download word was dropped
module rom_arbiter_n
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int ADDR_W          = 23,
  parameter int DATA_W          = 32,
  parameter int ARB_MODE        = 0,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DL_INDEX        = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [DATA_W-1:0]        ch_q,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_data,
  input  logic [15:0]              ioctl_index,
  input  logic                     ioctl_wr,
  input  logic                     ioctl_download,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [DATA_W-1:0]        sdram_data,
  output logic                     sdram_we,
  output logic                     sdram_req,
  input  logic                     sdram_ack,
  input  logic                     sdram_valid,
  input  logic [DATA_W-1:0]        sdram_q,
  output logic                     err_orphan,
  output logic                     err_overrun
);

  localparam int TAG_W = clog2_safe(NUM_CH);
  localparam int PTR_W = clog2_safe(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("rom_arbiter_n: DATA_W must be 32");
  end

  arb_state_e        state_q;
  logic [TAG_W-1:0]  grant_q;
  logic [TAG_W-1:0]  last_q;
  logic [ADDR_W-1:0] sdram_addr_q;
  logic [DATA_W-1:0] sdram_data_q;
  logic              sdram_we_q;
  logic              sdram_req_q;
  logic              orphan_q;
  logic [TAG_W-1:0]  tag_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pk_rdy_s;
  logic [22:0]       pk_addr_s;
  logic [31:0]       pk_data_s;
  logic              pk_busy_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              rd_ack_s;
  logic              wr_done_s;
  logic              pop_s;
  logic              rd_ok_s;
  logic [TAG_W-1:0]  win_s;
  logic [ADDR_W-1:0] win_addr_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  rom_download_packer u_packer (
    .clk              (clk),
    .reset_n          (reset_n),
    .ioctl_addr_i     (ioctl_addr),
    .ioctl_data_i     (ioctl_data),
    .ioctl_wr_i       (ioctl_wr),
    .ioctl_download_i (ioctl_download),
    .wr_done_i        (wr_done_s),
    .word_rdy_o       (pk_rdy_s),
    .word_addr_o      (pk_addr_s),
    .word_data_o      (pk_data_s),
    .busy_o           (pk_busy_s),
    .overrun_o        (err_overrun)
  );

  assign fifo_full_s  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty_s = (cnt_q == CNT_W'(0));
  assign rd_ack_s     = (state_q == RD_REQ) & sdram_ack;
  assign wr_done_s    = (state_q == WR_REQ) & sdram_ack;
  assign pop_s        = sdram_valid & ~fifo_empty_s;
  // Reads wait for the download, its trailing flush and a free tag slot.
  assign rd_ok_s      = ~ioctl_download & ~pk_busy_s & (|ch_req) & ~fifo_full_s;

  // Arbitration: lowest index, or first requester after the last grant.
  always_comb begin
    logic             found;
    logic [TAG_W-1:0] idx;
    win_s = '0;
    found = 1'b0;
    idx   = '0;
    if (ARB_MODE == ARB_RR) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        idx   = TAG_W'((int'(last_q) + off) % NUM_CH);
        win_s = (!found && ch_req[idx]) ? idx : win_s;
        found = found | ch_req[idx];
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        win_s = ch_req[i] ? TAG_W'(i) : win_s;
      end
    end
  end

  // Address of the winning channel.
  always_comb begin
    win_addr_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      win_addr_s = (win_s == TAG_W'(i)) ? ch_addr[i*ADDR_W +: ADDR_W] : win_addr_s;
    end
  end

  // One-hot ack to the held grant and valid to the oldest outstanding tag.
  always_comb begin
    ch_ack   = '0;
    ch_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i]   = rd_ack_s & (grant_q == TAG_W'(i));
      ch_valid[i] = pop_s & (tag_mem_q[rd_ptr_q] == TAG_W'(i));
    end
  end

  // Request FSM with registered SDRAM request outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= TAG_W'(NUM_CH - 1);
      sdram_addr_q <= '0;
      sdram_data_q <= '0;
      sdram_we_q   <= 1'b0;
      sdram_req_q  <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Download writes (including the flush) take priority over reads.
          if (pk_rdy_s) begin
            sdram_addr_q <= ADDR_W'(pk_addr_s);
            sdram_data_q <= pk_data_s;
            sdram_we_q   <= (ioctl_index == 16'(DL_INDEX));
            sdram_req_q  <= 1'b1;
            state_q      <= WR_REQ;
          end else if (rd_ok_s) begin
            sdram_addr_q <= win_addr_s;
            sdram_we_q   <= 1'b0;
            sdram_req_q  <= 1'b1;
            grant_q      <= win_s;
            state_q      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            last_q      <= grant_q;
            state_q     <= IDLE;
          end
        end
        WR_REQ: begin
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            sdram_we_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          sdram_req_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
      if (sdram_valid && fifo_empty_s) begin
        orphan_q <= 1'b1;
      end
    end
  end

  // Tag FIFO: grant pushed on read ack, popped on each returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      if (rd_ack_s) begin
        tag_mem_q[wr_ptr_q] <= grant_q;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({rd_ack_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign sdram_addr = sdram_addr_q;
  assign sdram_data = sdram_data_q;
  assign sdram_we   = sdram_we_q;
  assign sdram_req  = sdram_req_q;
  assign err_orphan = orphan_q;
  assign ch_q       = sdram_q;

endmodule

// File: tb/tb_rom_arbiter_n.sv
// Directed bench for rom_arbiter_n: a fixed-priority instance (dut) and a
// round-robin instance (dut_rr) share all inputs; each scenario task checks
// one of them against hand-computed values.
module tb_rom_arbiter_n;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    ch_req;
  logic [91:0]   ch_addr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_data;
  logic [15:0]   ioctl_index;
  logic          ioctl_wr;
  logic          ioctl_download;
  logic          sdram_ack;
  logic          sdram_valid;
  logic [31:0]   sdram_q;

  logic [3:0]  ch_ack, ch_valid, rr_ch_ack, rr_ch_valid;
  logic [31:0] ch_q, rr_ch_q, sdram_data, rr_sdram_data;
  logic [22:0] sdram_addr, rr_sdram_addr;
  logic        sdram_we, sdram_req, err_orphan, err_overrun;
  logic        rr_sdram_we, rr_sdram_req, rr_err_orphan, rr_err_overrun;

  logic [22:0] exp_addr [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_arbiter_n #(.NUM_CH(4), .ADDR_W(23), .DATA_W(32), .ARB_MODE(0),
                  .MAX_OUTSTANDING(2), .DL_INDEX(0)) dut (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_ack(ch_ack), .ch_valid(ch_valid), .ch_q(ch_q),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .sdram_q(sdram_q), .err_orphan(err_orphan), .err_overrun(err_overrun)
  );

  rom_arbiter_n #(.NUM_CH(4), .ADDR_W(23), .DATA_W(32), .ARB_MODE(1),
                  .MAX_OUTSTANDING(2), .DL_INDEX(0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_ack(rr_ch_ack), .ch_valid(rr_ch_valid), .ch_q(rr_ch_q),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(rr_sdram_addr), .sdram_data(rr_sdram_data), .sdram_we(rr_sdram_we),
    .sdram_req(rr_sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .sdram_q(sdram_q), .err_orphan(rr_err_orphan), .err_overrun(rr_err_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({sdram_req, sdram_we, sdram_addr, sdram_data} !== 57'd0) begin
      errors++;
      $display("FAIL reset_sdram: got req=%b we=%b addr=%h data=%h, expected all 0",
               sdram_req, sdram_we, sdram_addr, sdram_data);
    end
    checks++;
    if ({ch_ack, ch_valid, err_orphan, err_overrun} !== 10'd0) begin
      errors++;
      $display("FAIL reset_flags: got ack=%b valid=%b orphan=%b overrun=%b, expected 0",
               ch_ack, ch_valid, err_orphan, err_overrun);
    end
    reset_n = 1'b1;
    tick();
  endtask

  // ch1 and ch3 requesting: fixed priority always serves ch1.
  task automatic test_fixed_priority;
    ch_req = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      tick();
      sdram_valid = 1'b0;
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== exp_addr[1] || sdram_we !== 1'b0) begin
        errors++;
        $display("FAIL fixed_req[%0d]: got req=%b addr=%h we=%b, expected 1 %h 0",
                 n, sdram_req, sdram_addr, sdram_we, exp_addr[1]);
      end
      sdram_ack = 1'b1;
      #1;
      checks++;
      if (ch_ack !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_ack[%0d]: got %b expected 0010", n, ch_ack);
      end
      tick();
      sdram_ack = 1'b0;
      checks++;
      if (sdram_req !== 1'b0) begin
        errors++;
        $display("FAIL fixed_req_drop[%0d]: got %b expected 0", n, sdram_req);
      end
      sdram_valid = 1'b1;
      sdram_q = 32'hCAFE_0000 + n;
      #1;
      checks++;
      if (ch_valid !== 4'b0010 || ch_q !== 32'hCAFE_0000 + n) begin
        errors++;
        $display("FAIL fixed_valid[%0d]: got valid=%b q=%h expected 0010 %h",
                 n, ch_valid, ch_q, 32'hCAFE_0000 + n);
      end
    end
    ch_req = 4'b0000;
    tick();
    sdram_valid = 1'b0;
  endtask

  // All four requesting: round-robin order 0,1,2,3,0.
  task automatic test_round_robin;
    logic [3:0] oh;
    int         e;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ch_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e  = n % 4;
      oh = 4'b0001 << e;
      tick();
      sdram_valid = 1'b0;
      checks++;
      if (rr_sdram_req !== 1'b1 || rr_sdram_addr !== exp_addr[e]) begin
        errors++;
        $display("FAIL rr_req[%0d]: got req=%b addr=%h expected 1 %h",
                 n, rr_sdram_req, rr_sdram_addr, exp_addr[e]);
      end
      sdram_ack = 1'b1;
      #1;
      checks++;
      if (rr_ch_ack !== oh) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got %b expected %b", n, rr_ch_ack, oh);
      end
      tick();
      sdram_ack   = 1'b0;
      sdram_valid = 1'b1;
      #1;
      checks++;
      if (rr_ch_valid !== oh) begin
        errors++;
        $display("FAIL rr_valid[%0d]: got %b expected %b", n, rr_ch_valid, oh);
      end
    end
    ch_req = 4'b0000;
    tick();
    sdram_valid = 1'b0;
  endtask

  // Two reads in flight, third blocked on a full tag FIFO, then an orphan.
  task automatic test_outstanding;
    ch_req = 4'b0100;
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== exp_addr[2]) begin
      errors++;
      $display("FAIL out_req_ch2: got req=%b addr=%h expected 1 %h", sdram_req, sdram_addr, exp_addr[2]);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    ch_req    = 4'b0001;
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== exp_addr[0]) begin
      errors++;
      $display("FAIL out_req_ch0: got req=%b addr=%h expected 1 %h", sdram_req, sdram_addr, exp_addr[0]);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    ch_req    = 4'b0010;
    tick();
    tick();
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL out_full_block: got req=%b expected 0", sdram_req);
    end
    sdram_valid = 1'b1;
    #1;
    checks++;
    if (ch_valid !== 4'b0100) begin
      errors++;
      $display("FAIL out_valid_first: got %b expected 0100", ch_valid);
    end
    tick();
    #1;
    checks++;
    if (ch_valid !== 4'b0001 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL out_valid_second: got valid=%b req=%b expected 0001 0", ch_valid, sdram_req);
    end
    tick();
    sdram_valid = 1'b0;
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== exp_addr[1]) begin
      errors++;
      $display("FAIL out_third_grant: got req=%b addr=%h expected 1 %h", sdram_req, sdram_addr, exp_addr[1]);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    ch_req      = 4'b0000;
    sdram_valid = 1'b1;
    #1;
    checks++;
    if (ch_valid !== 4'b0010) begin
      errors++;
      $display("FAIL out_valid_third: got %b expected 0010", ch_valid);
    end
    tick();
    #1;
    checks++;
    if (ch_valid !== 4'b0000) begin
      errors++;
      $display("FAIL orphan_no_valid: got %b expected 0000", ch_valid);
    end
    tick();
    sdram_valid = 1'b0;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_flag: got %b expected 1", err_orphan);
    end
  endtask

  task automatic send_bytes(input logic [24:0] base, input logic [31:0] word, input int count);
    logic [31:0] w;
    w = word;
    for (int k = 0; k < count; k++) begin
      ioctl_addr = base + 25'(k);
      ioctl_data = w[8*(k%4) +: 8];
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
  endtask

  // One full word with index 0 (write) and index 1 (we low).
  task automatic test_download;
    ioctl_download = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      ioctl_index = 16'(pass);
      send_bytes(25'h100, 32'h4433_2211, 4);
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 23'h40 || sdram_data !== 32'h4433_2211 ||
          sdram_we !== (pass == 0)) begin
        errors++;
        $display("FAIL dl_write[%0d]: got req=%b addr=%h data=%h we=%b expected 1 40 44332211 %b",
                 pass, sdram_req, sdram_addr, sdram_data, sdram_we, pass == 0);
      end
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
    end
    ioctl_index    = 16'd0;
    ioctl_download = 1'b0;
    tick();
    tick();
    checks++;
    if (sdram_req !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL dl_no_flush: got req=%b overrun=%b expected 0 0", sdram_req, err_overrun);
    end
  endtask

  // Six bytes then download end: full word, flush word, then the blocked read.
  task automatic test_flush;
    ch_req         = 4'b0001;
    ioctl_download = 1'b1;
    send_bytes(25'h0, 32'h0403_0201, 4);
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 23'h0 || sdram_data !== 32'h0403_0201 || sdram_we !== 1'b1) begin
      errors++;
      $display("FAIL flush_first_word: got req=%b addr=%h data=%h we=%b expected 1 0 04030201 1",
               sdram_req, sdram_addr, sdram_data, sdram_we);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    send_bytes(25'h4, 32'h0000_BBAA, 2);
    ioctl_download = 1'b0;
    tick();
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_read_blocked: got req=%b expected 0", sdram_req);
    end
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 23'h1 || sdram_data !== 32'h0000_BBAA || sdram_we !== 1'b1) begin
      errors++;
      $display("FAIL flush_word: got req=%b addr=%h data=%h we=%b expected 1 1 0000bbaa 1",
               sdram_req, sdram_addr, sdram_data, sdram_we);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack_drop: got req=%b expected 0", sdram_req);
    end
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_we !== 1'b0 || sdram_addr !== exp_addr[0]) begin
      errors++;
      $display("FAIL flush_then_read: got req=%b we=%b addr=%h expected 1 0 %h",
               sdram_req, sdram_we, sdram_addr, exp_addr[0]);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    ch_req      = 4'b0000;
    sdram_valid = 1'b1;
    tick();
    sdram_valid = 1'b0;
  endtask

  // Second word completes while the first write is still unacked.
  task automatic test_overrun;
    ioctl_download = 1'b1;
    send_bytes(25'h200, 32'h1234_5678, 4);
    send_bytes(25'h204, 32'h9ABC_DEF0, 4);
    checks++;
    if (err_overrun !== 1'b1 || sdram_addr !== 23'h80 || sdram_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL overrun_keep_old: got ovr=%b addr=%h data=%h expected 1 80 12345678",
               err_overrun, sdram_addr, sdram_data);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL overrun_dropped: got req=%b expected 0", sdram_req);
    end
    ioctl_download = 1'b0;
    tick();
  endtask

  // Asynchronous reset in RD_REQ with one tag outstanding.
  task automatic test_async_reset;
    ch_req = 4'b0001;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    ch_req    = 4'b0010;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sdram_req, sdram_we, sdram_addr, sdram_data} !== 57'd0 || ch_ack !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got req=%b we=%b addr=%h data=%h ack=%b expected 0",
               sdram_req, sdram_we, sdram_addr, sdram_data, ch_ack);
    end
    checks++;
    if (err_orphan !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_flags: got orphan=%b overrun=%b expected 0 0", err_orphan, err_overrun);
    end
    ch_req = 4'b0000;
    tick();
    reset_n = 1'b1;
    tick();
    sdram_valid = 1'b1;
    #1;
    checks++;
    if (ch_valid !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_fifo_empty: got %b expected 0000", ch_valid);
    end
    tick();
    sdram_valid = 1'b0;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_orphan: got %b expected 1", err_orphan);
    end
  endtask

  initial begin
    exp_addr[0]    = 23'h000010;
    exp_addr[1]    = 23'h000111;
    exp_addr[2]    = 23'h000222;
    exp_addr[3]    = 23'h000333;
    ch_addr        = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
    reset_n        = 1'b0;
    ch_req         = 4'b0000;
    ioctl_addr     = 25'd0;
    ioctl_data     = 8'd0;
    ioctl_index    = 16'd0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    sdram_ack      = 1'b0;
    sdram_valid    = 1'b0;
    sdram_q        = 32'd0;

    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_outstanding();
    test_download();
    test_flush();
    test_overrun();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
